seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for a common-anode multi-digit 7-segment display. It is the parametrised successor to the single-digit hex decoder and adds several features: DIGITS digits scanned by a refresh counter, per-digit decimal point and blanking, a tear-free double-buffered value load, and optional leading-zero suppression. It sits between the datapath's hex value bus and the board's segment and anode pins.

## Interface

- DIGITS, 4: number of scanned digits; legal range 1..8.
- REFRESH_DIV, 100000: clk cycles each digit stays lit; minimum 1.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = scan and drive display; 0 = all digits dark and scan frozen.
- load  in  1  single-cycle strobe; captures value/dp_in into shadow buffer.
- value  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is digit i; digit 0 is rightmost.
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit.
- blank  in  DIGITS  live per-digit forced blank, 1 = digit dark (not buffered).
- a_to_g  out  7  active-low segments: [6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g.
- dp  out  1  active-low decimal point.
- an  out  DIGITS  active-low digit select, one-hot-low when a digit is lit.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0.

## Operation

- Reset state: div counter 0, digit index 0, shadow = active = 0, pending = 0. Outputs: a_to_g = 7'h7F, dp = 1, an = all ones, frame_done = 0.
- Divider: counts 0..REFRESH_DIV-1 while enable=1. At terminal count it returns to 0 and the digit index advances by 1, wrapping from DIGITS-1 to 0.
- Wrap: on the advance from DIGITS-1 to 0, frame_done pulses. If pending=1, the active buffer is loaded from shadow and pending clears.
- Load: when load=1, shadow is loaded from value/dp_in and pending is set. A newer load before the wrap overwrites shadow, so only the last load applies.
- Load coincident with wrap: the wrap copies the old shadow contents. The new value enters shadow with pending=1 and is applied at the next wrap.
- Decode: standard hex glyphs, shown here as a_to_g[6:0]:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- Digit output: the current digit i is driven with an[i]=0, its glyph, and dp=~dp_active[i].
- Blanking: a digit is blanked when blank[i]=1 (or by LZB, see Configuration). A blanked digit still has an[i]=0 but drives a_to_g=7'h7F and dp=1.
- enable=0: an = all ones, a_to_g = 7'h7F, dp = 1. The divider and index hold their values, and scanning resumes from the same point when enable returns to 1. Loads are still accepted while enable=0.

## Timing

- All outputs are registered. an, a_to_g and dp reflect the digit index and buffers with a 1-cycle latency.
- frame_done is asserted in the cycle after the wrap edge, aligned with the first cycle digit 0 is displayed.
- Each digit is lit for exactly REFRESH_DIV cycles. One frame is DIGITS*REFRESH_DIV cycles.
- REFRESH_DIV=1: the index advances every cycle.
- DIGITS=1: every terminal count is a wrap, and frame_done pulses every REFRESH_DIV cycles.
- Effect of a load on the display: it becomes visible no earlier than the first digit-0 cycle after the next wrap.
- Reset mid-scan: all state and outputs return to their reset values immediately, independent of clk, and pending loads are discarded.
- Display after rst deasserts (enable=1): first output cycle is digit 0 with active=0, i.e. glyph "0" on digit 0.

## Configuration

- SEG7_LZB_EN defined: leading-zero blanking is enabled.
  - Digit i (i≥1) is blanked when active nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never LZB-blanked.
  - dp of an LZB-blanked digit is still driven from dp_active.
- SEG7_LZB_EN undefined: all digits show their nibble, including leading zeros; only blank[] blanks.

## Test plan

All cases use DIGITS=4 and REFRESH_DIV=4.

- Reset then enable=1, no load -> outputs follow this sequence:
  - an cycles 1110, 1101, 1011, 0111, 4 cycles each.
  - a_to_g = 0000001 throughout (or digits 1-3 = 1111111 with SEG7_LZB_EN).
  - frame_done pulses every 16 cycles.
- load value=16'hA1b8, dp_in=4'b0010 mid-frame -> old digits hold until the wrap. After frame_done, outputs are:
  - digit0 = 0000000 (8)
  - digit1 = 1100000 (b), with dp=0
  - digit2 = 1001111 (1)
  - digit3 = 0001000 (A)
- load 16'h1234, then load 16'h5678 in the same frame -> only 5678 is ever displayed. Also load 16'h9999 on the wrap cycle -> 9999 appears one frame later.
- blank=4'b0100 with value 16'h8888 -> when an=1011, a_to_g=7'h7F and dp=1; other digits show 0000000.
- enable dropped during digit 2 for 10 cycles -> an=1111 for those cycles, then digit 2 resumes with the divider count preserved. Then assert rst mid-digit -> outputs are at reset values in the same cycle.
- SEG7_LZB_EN with value 16'h0040 -> digits 3 and 2 blank, digit 1 = 1001100 (4), digit 0 = 0000001 (0). Value 16'h0000 -> only digit 0 is lit.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment driver with a double-buffered value load.
// Define SEG7_LZB_EN to enable leading-zero blanking of the upper digits.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    output logic [6:0]            a_to_g,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            4'hF:    seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [DIV_W-1:0]    div_cnt_r;
    logic [IDX_W-1:0]    idx_r;
    logic [4*DIGITS-1:0] shadow_val_r;
    logic [DIGITS-1:0]   shadow_dp_r;
    logic [4*DIGITS-1:0] active_val_r;
    logic [DIGITS-1:0]   active_dp_r;
    logic                pending_r;
    logic                wrap_r;
    logic [6:0]          a_to_g_r;
    logic                dp_r;
    logic [DIGITS-1:0]   an_r;
    logic                frame_done_r;

    logic                terminal_s;
    logic                wrap_s;
    logic [3:0]          nibble_s;
    logic                cur_dp_s;
    logic                cur_blank_s;
    logic                cur_lzb_s;
    logic [DIGITS-1:0]   lzb_mask_s;
    logic [DIGITS-1:0]   sel_an_s;
    logic [6:0]          next_seg_s;
    logic                next_dp_s;
    logic [DIGITS-1:0]   next_an_s;

    // Scan timing: end of a digit slot and end of a whole frame.
    always_comb begin
        terminal_s = enable && (div_cnt_r == DIV_LAST);
        wrap_s     = terminal_s && (idx_r == IDX_LAST);
    end

    // Leading-zero mask: digit i dark when it and every nibble above it are zero.
    always_comb begin
        lzb_mask_s = '0;
`ifdef SEG7_LZB_EN
        begin : lzb_scan
            logic all_zero;
            all_zero = 1'b1;
            for (int i = DIGITS - 1; i >= 0; i--) begin
                all_zero      = all_zero && (active_val_r[4*i +: 4] == 4'h0);
                lzb_mask_s[i] = (i != 0) && all_zero;
            end
        end
`endif
    end

    // Select the fields of the digit currently being scanned.
    always_comb begin
        nibble_s    = 4'h0;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b0;
        cur_lzb_s   = 1'b0;
        sel_an_s    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            sel_an_s[i] = (idx_r != IDX_W'(i));
            nibble_s    = (idx_r == IDX_W'(i)) ? active_val_r[4*i +: 4] : nibble_s;
            cur_dp_s    = (idx_r == IDX_W'(i)) ? active_dp_r[i]         : cur_dp_s;
            cur_blank_s = (idx_r == IDX_W'(i)) ? blank[i]               : cur_blank_s;
            cur_lzb_s   = (idx_r == IDX_W'(i)) ? lzb_mask_s[i]          : cur_lzb_s;
        end
    end

    // Next pin values; a forced blank also darkens dp, leading-zero blanking does not.
    always_comb begin
        next_an_s  = '1;
        next_seg_s = 7'h7F;
        next_dp_s  = 1'b1;
        if (enable) begin
            next_an_s = sel_an_s;
            if (cur_blank_s || cur_lzb_s) begin
                next_seg_s = 7'h7F;
            end else begin
                next_seg_s = hex_glyph(nibble_s);
            end
            if (cur_blank_s) begin
                next_dp_s = 1'b1;
            end else begin
                next_dp_s = ~cur_dp_s;
            end
        end else begin
            next_an_s  = '1;
            next_seg_s = 7'h7F;
            next_dp_s  = 1'b1;
        end
    end

    // Refresh divider and digit index; both freeze while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= '0;
            idx_r     <= '0;
        end else if (terminal_s) begin
            div_cnt_r <= '0;
            idx_r     <= (idx_r == IDX_LAST) ? IDX_W'(0) : idx_r + IDX_W'(1);
        end else if (enable) begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Double buffer: a frame wrap copies the old shadow before a coincident load lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_val_r <= '0;
            shadow_dp_r  <= '0;
            active_val_r <= '0;
            active_dp_r  <= '0;
            pending_r    <= 1'b0;
        end else begin
            if (wrap_s && pending_r) begin
                active_val_r <= shadow_val_r;
                active_dp_r  <= shadow_dp_r;
            end
            if (load) begin
                shadow_val_r <= value;
                shadow_dp_r  <= dp_in;
                pending_r    <= 1'b1;
            end else if (wrap_s) begin
                pending_r    <= 1'b0;
            end
        end
    end

    // Registered pins; frame_done trails the wrap edge to line up with digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_to_g_r     <= 7'h7F;
            dp_r         <= 1'b1;
            an_r         <= '1;
            wrap_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            a_to_g_r     <= next_seg_s;
            dp_r         <= next_dp_s;
            an_r         <= next_an_s;
            wrap_r       <= wrap_s;
            frame_done_r <= wrap_r;
        end
    end

    assign a_to_g     = a_to_g_r;
    assign dp         = dp_r;
    assign an         = an_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4); follows SEG7_LZB_EN.
module tb_seg7_scan_driver;

    localparam int D = 4;
    localparam int R = 4;
    localparam int F = D * R;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [6:0]  a_to_g;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .blank(blank), .a_to_g(a_to_g), .dp(dp), .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   nchk = 0;
    int   nerr = 0;

    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Reference model: position within the frame, shadow/active buffers, pending flag
    int          pos = 0;
    logic [15:0] sh_v = 16'h0, act_v = 16'h0;
    logic [3:0]  sh_dp = 4'h0, act_dp = 4'h0;
    bit          pend = 1'b0;
    bit          wrap_prev = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos = 0; sh_v = 16'h0; act_v = 16'h0; sh_dp = 4'h0; act_dp = 4'h0;
        pend = 1'b0; wrap_prev = 1'b0;
    endtask

    // One clock: drive inputs, predict the pins after the edge, advance the model.
    task automatic tick(input bit e, input bit l, input logic [15:0] v,
                        input logic [3:0] d, input logic [3:0] b);
        exp_t x;
        int   dig;
        bit   forced, lead, wrap;
        logic [3:0] nib;
        enable = e; load = l; value = v; dp_in = d; blank = b;
        x.fd = wrap_prev;
        if (e) begin
            dig    = pos / R;
            nib    = act_v[4*dig +: 4];
            forced = b[dig];
            lead   = 1'b0;
`ifdef SEG7_LZB_EN
            lead   = (dig >= 1) && ((act_v >> (4*dig)) == 16'h0);
`endif
            x.an  = 4'hF & ~(4'b0001 << dig);
            x.seg = (forced || lead) ? 7'h7F : glyph[nib];
            x.dp  = forced ? 1'b1 : ~act_dp[dig];
        end else begin
            x.an = 4'hF; x.seg = 7'h7F; x.dp = 1'b1;
        end
        wrap = e && (pos == F - 1);
        if (e) pos = (pos + 1) % F;
        if (wrap && pend) begin
            act_v = sh_v; act_dp = sh_dp; pend = 1'b0;
        end
        if (l) begin
            sh_v = v; sh_dp = d; pend = 1'b1;
        end
        wrap_prev = wrap;
        @(posedge clk);
        q.push_back(x);
        #1;
    endtask

    task automatic idle(input int n, input logic [3:0] b);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 16'($urandom), 4'($urandom), b);
    endtask

    task automatic until_pos(input int p);
        while (pos != p) tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_seg"}, 32'(a_to_g), 32'h7F);
        check({tag, "_dp"}, 32'(dp), 32'h1);
        check({tag, "_fd"}, 32'(frame_done), 32'h0);
    endtask

    // Monitor: one registered output per cycle, compared on the falling edge.
    always @(negedge clk) begin
        exp_t x;
        if (!rst && q.size() > 0) begin
            x = q.pop_front();
            check("an", 32'(an), 32'(x.an));
            check("a_to_g", 32'(a_to_g), 32'(x.seg));
            check("dp", 32'(dp), 32'(x.dp));
            check("frame_done", 32'(frame_done), 32'(x.fd));
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_pins("reset");
        rst = 1'b0;

        // Free run from reset: digit 0 first, glyph 0, frame_done every 16 cycles
        idle(40, 4'h0);

        // Mid-frame load shows only after the wrap
        until_pos(6);
        tick(1'b1, 1'b1, 16'hA1B8, 4'b0010, 4'h0);
        idle(40, 4'h0);

        // Two loads in one frame, then a load on the wrap cycle
        until_pos(2);
        tick(1'b1, 1'b1, 16'h1234, 4'h0, 4'h0);
        idle(3, 4'h0);
        tick(1'b1, 1'b1, 16'h5678, 4'h0, 4'h0);
        idle(20, 4'h0);
        until_pos(F - 1);
        tick(1'b1, 1'b1, 16'h9999, 4'h0, 4'h0);
        idle(40, 4'h0);

        // Live blank of digit 2 with all-8 digits
        tick(1'b1, 1'b1, 16'h8888, 4'h0, 4'b0100);
        idle(40, 4'b0100);

        // LZB patterns (full display when LZB is off)
        tick(1'b1, 1'b1, 16'h0040, 4'b0100, 4'h0);
        idle(36, 4'h0);
        tick(1'b1, 1'b1, 16'h0000, 4'b1111, 4'h0);
        idle(36, 4'h0);

        // Disable during digit 2, resume from the same count
        until_pos(2 * R + 1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
        idle(20, 4'h0);

        // Asynchronous reset mid-digit discards a pending load
        tick(1'b1, 1'b1, 16'hFEDC, 4'hF, 4'h0);
        until_pos(2 * R + 2);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        check_reset_pins("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(36, 4'h0);

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            logic [15:0] v;
            v = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            tick($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, v, 4'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        end

        @(negedge clk);
        #1;
        if (q.size() != 0) check("queue_drain", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
